// File: rtl/pe_operand_src_pkg.sv
// Shared types and build defaults for the PE operand source and its pair FIFO.
// The package defaults describe the standard 32-bit, 4-deep configuration.
package pe_operand_src_pkg;

  localparam int PE_SRC_DATA_WIDTH = 32;
  localparam int PE_SRC_DEPTH      = 4;
  localparam int PE_SRC_PTR_W      = $clog2(PE_SRC_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic [PE_SRC_DATA_WIDTH-1:0] a;
    logic [PE_SRC_DATA_WIDTH-1:0] b;
  } operand_pair_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pe_operand_src_fifo.sv
// Operand-pair FIFO: DEPTH entries, extra-bit pointers, registered head read.
// Latency: a push at edge E0 is visible at the head after E0 (no write-through).
// Backpressure: full blocks push, empty blocks pop; push and pop may share a cycle.
module pe_operand_src_fifo
  import pe_operand_src_pkg::*;
#(
  parameter int W     = 2 * PE_SRC_DATA_WIDTH,
  parameter int DEPTH = PE_SRC_DEPTH,
  parameter int AW    = PE_SRC_PTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          push_ok, pop_ok;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head_dat = mem_q[rd_idx];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_idx] = push_dat;
      wr_ptr_d      = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/pe_operand_src.sv
// Forks queued operand pairs onto two valid/ready channels and collects PE results (stats: LOOM_PE_SRC_STATS_EN).
// Latency: first operand valid 2 edges after push; back-to-back pairs issue at 1 pair/cycle.
// Backpressure: each channel holds valid until its own handshake; issue stalls at MAX_OUTSTANDING unanswered pairs.
module pe_operand_src
  import pe_operand_src_pkg::*;
#(
  parameter int DATA_WIDTH      = PE_SRC_DATA_WIDTH,
  parameter int DEPTH           = PE_SRC_DEPTH,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_a,
  input  logic [DATA_WIDTH-1:0] push_b,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic [DATA_WIDTH-1:0] last_result,
  output logic [CNT_WIDTH-1:0]  result_count,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  busy
`ifdef LOOM_PE_SRC_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cycles
`endif
);

  localparam int                   PTR_W    = ptr_width(DEPTH);
  localparam logic [CNT_WIDTH-1:0] MAX_OUT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_W:0]       ONE_PAIR = (PTR_W + 1)'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } pair_t;

  state_e                state_q, state_d;
  logic                  sent0_q, sent0_d;
  logic                  sent1_q, sent1_d;
  logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]  result_count_q, result_count_d;
  logic [DATA_WIDTH-1:0] last_result_q, last_result_d;

  pair_t                 push_pair, head;
  logic                  fifo_full, fifo_empty;
  logic [PTR_W:0]        fifo_count;
  logic                  issue, fire0, fire1, retire, push_fire, res_fire;

  assign push_pair = {push_a, push_b};
  assign push_fire = push_valid & ~fifo_full;

  pe_operand_src_fifo #(
    .W     ($bits(pair_t)),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_fire),
    .push_dat (push_pair),
    .pop      (retire),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign issue      = (state_q == ISSUE);
  assign out0_valid = issue & ~sent0_q;
  assign out1_valid = issue & ~sent1_q;
  assign out0_data  = head.a;
  assign out1_data  = head.b;
  assign fire0      = out0_valid & out0_ready;
  assign fire1      = out1_valid & out1_ready;
  // A channel that already handed over its operand counts as done for this pair.
  assign retire     = issue & (sent0_q | fire0) & (sent1_q | fire1);

  assign res_ready  = (outstanding_q != '0);
  assign res_fire   = res_valid & res_ready;

  assign push_ready   = ~fifo_full;
  assign last_result  = last_result_q;
  assign result_count = result_count_q;
  assign outstanding  = outstanding_q;
  assign busy         = ~fifo_empty | issue | (outstanding_q != '0);

  always_comb begin
    sent0_d        = sent0_q;
    sent1_d        = sent1_q;
    state_d        = state_q;
    last_result_d  = last_result_q;
    result_count_d = result_count_q;
    outstanding_d  = outstanding_q + CNT_WIDTH'(retire) - CNT_WIDTH'(res_fire);

    if (retire) begin
      sent0_d = 1'b0;
      sent1_d = 1'b0;
    end else begin
      if (fire0) sent0_d = 1'b1;
      if (fire1) sent1_d = 1'b1;
    end

    if (res_fire) begin
      last_result_d  = res_data;
      result_count_d = result_count_q + 1'b1;
    end

    // Continuing in ISSUE needs a pair that was already resident before this pop.
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (outstanding_q < MAX_OUT)) state_d = ISSUE;
      end
      ISSUE: begin
        if (retire && !((fifo_count > ONE_PAIR) && (outstanding_d < MAX_OUT))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sent0_q        <= 1'b0;
      sent1_q        <= 1'b0;
      outstanding_q  <= '0;
      result_count_q <= '0;
      last_result_q  <= '0;
    end else begin
      state_q        <= state_d;
      sent0_q        <= sent0_d;
      sent1_q        <= sent1_d;
      outstanding_q  <= outstanding_d;
      result_count_q <= result_count_d;
      last_result_q  <= last_result_d;
    end
  end

`ifdef LOOM_PE_SRC_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic                 stall;

  assign stall        = (out0_valid & ~out0_ready) | (out1_valid & ~out1_ready);
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end
`endif

endmodule

// File: tb/tb_pe_operand_src.sv
// Bench for pe_operand_src: operand vector table, multi-cycle corner sequences and a transfer scoreboard.
module tb_pe_operand_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid, push_ready;
  logic [31:0] push_a, push_b;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data, last_result;
  logic [15:0] result_count, outstanding;
  logic        busy;
`ifdef LOOM_PE_SRC_STATS_EN
  logic [15:0] stall_cycles;
`endif

  pe_operand_src dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_a       (push_a),
    .push_b       (push_b),
    .out0_valid   (out0_valid),
    .out0_ready   (out0_ready),
    .out0_data    (out0_data),
    .out1_valid   (out1_valid),
    .out1_ready   (out1_ready),
    .out1_data    (out1_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .last_result  (last_result),
    .result_count (result_count),
    .outstanding  (outstanding),
    .busy         (busy)
`ifdef LOOM_PE_SRC_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: operands enter at push fire and must leave exactly once, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (push_valid && push_ready) begin
        q0.push_back(push_a);
        q1.push_back(push_b);
      end
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("ch0_unexpected_transfer", out0_data, 32'hDEAD_0000);
        else chk("ch0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("ch1_unexpected_transfer", out1_data, 32'hDEAD_0001);
        else chk("ch1_data", out1_data, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 32'd3,          b: 32'd5,          res: 32'd8};
    vecs[1] = '{a: 32'hFFFF_FFFE,  b: 32'd1,          res: 32'hFFFF_FFFF};
    vecs[2] = '{a: 32'd0,          b: 32'd0,          res: 32'd0};
    vecs[3] = '{a: 32'hAAAA_5555,  b: 32'h5555_AAAA,  res: 32'hFFFF_FFFF};
    vecs[4] = '{a: 32'd1,          b: 32'hFFFF_FFFF,  res: 32'd0};

    rst_n = 1'b0; push_valid = 1'b0; push_a = '0; push_b = '0;
    out0_ready = 1'b0; out1_ready = 1'b0; res_valid = 1'b0; res_data = '0;

    // Reset state, held and released
    repeat (3) step();
    for (int r = 0; r < 2; r++) begin
      chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
      chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
      chk("rst_res_ready", {31'd0, res_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result_count", {16'd0, result_count}, 32'd0);
      rst_n = 1'b1;
      step();
    end

    // Table: single pair, both channels ready, result echoed one cycle after retire
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_valid = 1'b1; push_a = vecs[i].a; push_b = vecs[i].b;
      step();
      push_valid = 1'b0;
      chk("vec_valid_after_1_edge", {31'd0, out0_valid}, 32'd0);
      step();
      chk("vec_out0_valid", {31'd0, out0_valid}, 32'd1);
      chk("vec_out1_valid", {31'd0, out1_valid}, 32'd1);
      chk("vec_out0_data", out0_data, vecs[i].a);
      chk("vec_out1_data", out1_data, vecs[i].b);
      step();
      chk("vec_outstanding", {16'd0, outstanding}, 32'd1);
      chk("vec_res_ready", {31'd0, res_ready}, 32'd1);
      res_valid = 1'b1; res_data = vecs[i].res;
      step();
      res_valid = 1'b0;
      chk("vec_last_result", last_result, vecs[i].res);
      chk("vec_result_count", {16'd0, result_count}, i + 1);
      chk("vec_busy_after", {31'd0, busy}, 32'd0);
    end

    // Channel 1 stalls while channel 0 completes; single retire
    out0_ready = 1'b1; out1_ready = 1'b0;
    push_valid = 1'b1; push_a = 32'd7; push_b = 32'd9;
    step();
    push_valid = 1'b0;
    step();
    chk("fork_both_valid", {30'd0, out0_valid, out1_valid}, 32'd3);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("fork_out0_dropped", {31'd0, out0_valid}, 32'd0);
      chk("fork_out1_held", {31'd0, out1_valid}, 32'd1);
      chk("fork_out1_data", out1_data, 32'd9);
    end
    out1_ready = 1'b1;
    step();
    chk("fork_retired_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
    chk("fork_outstanding", {16'd0, outstanding}, 32'd1);
    res_valid = 1'b1; res_data = 32'd16;
    step();
    res_valid = 1'b0;
    chk("fork_result_count", {16'd0, result_count}, 32'd6);

    // FIFO fill with both readies low, then outstanding limit
    out0_ready = 1'b0; out1_ready = 1'b0;
    push_valid = 1'b1;
    for (int p = 0; p < 4; p++) begin
      push_a = 32'd10 + p; push_b = 32'd20 + p;
      chk("fill_push_ready", {31'd0, push_ready}, 32'd1);
      step();
    end
    chk("full_push_ready", {31'd0, push_ready}, 32'd0);
    push_a = 32'd14; push_b = 32'd24;
    step();
    chk("full_push_stalled", {31'd0, push_ready}, 32'd0);
    chk("full_head_a", out0_data, 32'd10);
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    chk("b2b_push_ready", {31'd0, push_ready}, 32'd1);
    chk("b2b_outstanding", {16'd0, outstanding}, 32'd1);
    chk("b2b_next_valid", {31'd0, out0_valid}, 32'd1);
    chk("b2b_next_data", out0_data, 32'd11);
    step();
    push_valid = 1'b0;
    chk("limit_outstanding", {16'd0, outstanding}, 32'd2);
    chk("limit_idle", {31'd0, out0_valid}, 32'd0);
    step();
    chk("limit_hold_idle", {31'd0, out0_valid | out1_valid}, 32'd0);
    chk("limit_hold_outstanding", {16'd0, outstanding}, 32'd2);
    res_valid = 1'b1; res_data = 32'd30;
    step();
    res_valid = 1'b0;
    chk("limit_after_res_outstanding", {16'd0, outstanding}, 32'd1);
    chk("limit_after_res_count", {16'd0, result_count}, 32'd7);
    chk("limit_after_res_idle", {31'd0, out0_valid}, 32'd0);
    step();
    chk("limit_reissue_valid", {31'd0, out0_valid}, 32'd1);
    chk("limit_reissue_data", out0_data, 32'd12);

    // Drain everything
    res_valid = 1'b1; res_data = 32'h77;
    for (int w = 0; w < 40 && busy; w++) step();
    res_valid = 1'b0;
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_result_count", {16'd0, result_count}, 32'd11);
    chk("drain_last_result", last_result, 32'h77);
    chk("drain_q0_empty", q0.size(), 32'd0);
    chk("drain_q1_empty", q1.size(), 32'd0);

    // Asynchronous reset during ISSUE with a pair still pending
    out0_ready = 1'b0; out1_ready = 1'b0;
    push_valid = 1'b1; push_a = 32'h1111; push_b = 32'h2222;
    step();
    push_a = 32'h3333; push_b = 32'h4444;
    step();
    push_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out0_valid}, 32'd1);
    chk("pre_rst_data", out0_data, 32'h1111);
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    out0_ready = 1'b0; out1_ready = 1'b0;
    chk("pre_rst_outstanding", {16'd0, outstanding}, 32'd1);
    chk("pre_rst_pending_data", out0_data, 32'h3333);
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    chk("mid_rst_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
    chk("mid_rst_outstanding", {16'd0, outstanding}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_push_ready", {31'd0, push_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_valid", {31'd0, out0_valid}, 32'd0);
    chk("post_rst_result_count", {16'd0, result_count}, 32'd0);
    chk("post_rst_last_result", last_result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_operand_src.md
Name: pe_operand_src

Overview:
- Operand transmitter and result collector for a two-input, one-output valid/ready PE such as pe_top.
- Host pushes operand pairs into an internal FIFO. The block forks each pair onto two independent valid/ready channels (to the PE in0/in1) and collects the PE result stream.
- Throttles issue on a maximum-outstanding limit.
- Used as the drive side in PE-level integration and as a reusable stream source in fabric tiles.

Parameters:
- DATA_WIDTH, 32, width of operands and results.
- DEPTH, 4, operand-pair FIFO entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2, maximum retired pairs awaiting results; at least 1.
- CNT_WIDTH, 16, width of the result and outstanding counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- push_valid  in  1  host pair valid.
- push_ready  out  1  FIFO not full.
- push_a  in  DATA_WIDTH  operand for channel 0.
- push_b  in  DATA_WIDTH  operand for channel 1.
- out0_valid/out0_ready/out0_data  out/in/out  1/1/DATA_WIDTH  channel 0 (to PE in0).
- out1_valid/out1_ready/out1_data  out/in/out  1/1/DATA_WIDTH  channel 1 (to PE in1).
- res_valid/res_ready/res_data  in/out/in  1/1/DATA_WIDTH  result stream from PE.
- last_result  out  DATA_WIDTH  most recent accepted result.
- result_count  out  CNT_WIDTH  results accepted since reset; wraps.
- outstanding  out  CNT_WIDTH  retired pairs not yet answered.
- busy  out  1  FIFO non-empty, or state ISSUE, or outstanding != 0.

Behaviour:
- Reset (async, rst_n=0), all registers cleared:
  - state=IDLE; FIFO empty; sent0=sent1=0.
  - out0_valid=out1_valid=0; push_ready=1; res_ready=0.
  - last_result=0; result_count=0; outstanding=0; busy=0.
- Reset mid-operation discards queued and partially sent pairs; outputs drop the same cycle rst_n falls.
- FIFO:
  - push fire = push_valid & push_ready; push_ready = !full.
  - No write-through. A pair pushed at edge E0 is visible at the head after E0.
  - Push and pop in the same cycle are both honoured; count unchanged.
- States:
  - IDLE -> ISSUE at an edge when FIFO non-empty and outstanding < MAX_OUTSTANDING.
  - Otherwise IDLE holds. First valid is asserted after E1, i.e. 2 edges after the push fire.
- Outputs:
  - out0_valid = (state==ISSUE) & !sent0; out1_valid = (state==ISSUE) & !sent1.
  - out0_data = head.a; out1_data = head.b; head is stable throughout ISSUE.
- Fork:
  - fireN = outN_valid & outN_ready.
  - retire = (sent0|fire0) & (sent1|fire1).
  - On retire: pop head, clear both sent flags, outstanding += 1.
  - Otherwise set sentN for each fired channel.
  - A valid, once high, drops only after its own handshake; each operand is transferred exactly once per pair.
- ISSUE exit at retire:
  - Stays ISSUE when the FIFO holds another pair after the pop and outstanding_next < MAX_OUTSTANDING. Back-to-back issue gives 1 pair/cycle.
  - Else -> IDLE.
- Results:
  - res_ready = (outstanding != 0).
  - On res fire: last_result <= res_data; result_count += 1 (wraps at 2^CNT_WIDTH).
  - outstanding_next = outstanding + retire - res_fire. Simultaneous retire and res fire leaves it unchanged.
- Arithmetic: all counters are modulo; data is passed through unmodified with no width conversion.

Optional Feature:
- Macro LOOM_PE_SRC_STATS_EN.
- Defined: adds output stall_cycles [CNT_WIDTH]. It counts cycles where (out0_valid & !out0_ready) | (out1_valid & !out1_ready), saturating at all-ones, cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package pe_operand_src_pkg:
  - state enum {IDLE, ISSUE}.
  - Packed struct operand_pair_t {a, b}, parameterised via DATA_WIDTH localparam default.
  - localparam for pointer width = $clog2(DEPTH).
- Sub-module pe_operand_src_fifo: synchronous DEPTH-entry FIFO with extra-bit pointers, full/empty, head read.
- Top holds the FSM, fork flags, result logic and optional stats.

Test Plan:
1. Reset held 3 cycles -> out0/out1_valid=0, push_ready=1, res_ready=0, busy=0, result_count=0; then assert rst_n -> values unchanged.
2. Push (3,5) with both readies high; echo PE res 8 one cycle after retire -> out0_data=3 and out1_data=5 valid 2 edges after push; last_result=8; result_count=1; busy=0 afterwards.
3. Push (7,9); out0_ready=1, out1_ready=0 for 3 cycles -> out0 fires once then drops; out1_valid holds 9. Raise out1_ready -> single retire, outstanding=1, no duplicate transfer on out0.
4. Both readies 0; push 5 pairs back-to-back -> push_ready=0 after 4th accepted; 5th stalls until the first retire frees an entry.
5. MAX_OUTSTANDING=2, res_valid=0; queue 3 pairs -> exactly 2 retire, state IDLE, outstanding=2. Deliver one result -> third pair issues next cycle.
6. Push (32'hFFFF_FFFE, 1), result 32'hFFFF_FFFF -> last_result=FFFFFFFF. Then assert rst_n low during ISSUE with a pair pending -> all valids 0 immediately, FIFO empty, outstanding=0.
